mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one downstream memory port between NUM_REQ single-beat requesters (A, B, C operand/result
//  ports of systolic_array_top). Round-robin arbitration, one outstanding transaction at a time,
//  read data broadcast to all requesters, per-requester ack pulse. Sits between the matrix engine
//  and the memory model/controller.
// PARAMETERS
//  NUM_REQ          3    number of requesters (2..8); index 0 = A, 1 = B, 2 = C
//  ADDR_WIDTH       16   address width, bits
//  BUS_WIDTH_BYTES  32   data bus width in bytes; DW = 8*BUS_WIDTH_BYTES
// PORTS
//  clk          in   1                 clock, all logic on rising edge
//  reset_n      in   1                 asynchronous active-low reset
//  req_i        in   NUM_REQ           per-requester request, level; held until ack
//  we_i         in   NUM_REQ           per-requester write enable (1 = write)
//  addr_i       in   NUM_REQ*ADDR_WIDTH packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  wdata_i      in   NUM_REQ*DW        packed write data, requester i at [i*DW +: DW]
//  ack_o        out  NUM_REQ           one-cycle completion pulse to granted requester
//  rdata_o      out  DW                read data, valid in ack cycle (broadcast)
//  mem_req_o    out  1                 downstream request, level
//  mem_we_o     out  1                 downstream write enable
//  mem_addr_o   out  ADDR_WIDTH        downstream address
//  mem_wdata_o  out  DW                downstream write data
//  mem_ack_i    in   1                 downstream completion, one-cycle pulse; rdata valid with it
//  mem_rdata_i  in   DW                downstream read data
//  stat_clear_i in   1                 [MEM_ARB_STATS_EN] synchronous clear of counters
//  grant_cnt_o  out  NUM_REQ*32        [MEM_ARB_STATS_EN] completed transactions per requester
//  wait_cnt_o   out  NUM_REQ*32        [MEM_ARB_STATS_EN] cycles requester i had req high, no ack
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = 0, counters 0. Reset mid-transaction abandons it,
//   no ack issued; downstream must also be reset.
//  FSM IDLE -> ISSUE -> RESP -> IDLE; all outputs registered.
//  IDLE: if any req_i high, pick first requester at or after rr pointer (wrap at NUM_REQ-1 -> 0);
//   latch grant index, we, addr, wdata; go ISSUE. mem_req_o rises the following cycle.
//  ISSUE: mem_req_o=1 with latched we/addr/wdata, stable. On mem_ack_i: capture mem_rdata_i into
//   rdata_o, mem_req_o<=0, ack_o[grant]<=1, go RESP. No timeout; waits indefinitely.
//  RESP: ack_o[grant] high exactly one cycle; rr pointer <= grant+1 (wrap); go IDLE.
//  Latency: req_i high in IDLE at edge k -> mem_req_o high from k+1; mem_ack_i at edge j ->
//   ack_o high cycle after j. Minimum 3 cycles per transaction, mem_ack_i same cycle as request.
//  Requester rule: drop req_i (or present next request) on the edge ending its ack cycle;
//   req_i still high in next IDLE cycle is a new transaction. Payload changes while waiting
//   are ignored (latched at grant). req_i dropped before ack: transaction still completes, ack issued.
//  Simultaneous requests: strict round-robin; with all high, grant order 0,1,2,0,... No starvation:
//   each waiting requester served within NUM_REQ transactions.
//  mem_ack_i outside ISSUE is ignored. rdata_o holds last captured value until next read ack
//   (write acks leave rdata_o unchanged).
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: stat_clear_i/grant_cnt_o/wait_cnt_o present. grant_cnt[i]++ on
//   ack_o[i]; wait_cnt[i]++ each cycle req_i[i]=1 and ack_o[i]=0. 32-bit, saturate at 2^32-1.
//   stat_clear_i has priority over increment; clears to 0 next cycle.
//  Not defined: these ports and counters do not exist; arbitration behaviour identical.
// TESTING
//  1 Reset: reset_n=0 mid-ISSUE -> mem_req_o=0, ack_o=0 immediately; after release single req
//    from B granted first (rr=0, A idle).
//  2 Single read: A req addr 0x0040, mem_ack_i 2 cycles after mem_req_o rises, rdata 0xA5..A5
//    -> mem_addr_o=0x0040, mem_we_o=0, ack_o=3'b001 one cycle, rdata_o=0xA5..A5.
//  3 Contention: A,B,C all held high, mem_ack_i same cycle -> grants A,B,C,A; each ack spaced
//    3 cycles; rr pointer wraps 2 -> 0.
//  4 Write: C we=1 addr 0x1000 wdata 0x1234 -> mem_we_o=1, mem_wdata_o=0x1234, rdata_o unchanged.
//  5 Back-to-back: A keeps req high after ack, B high -> B served before A's second transaction.
//  6 Stats (MEM_ARB_STATS_EN): scenario 3 for 6 transactions -> grant_cnt={2,2,2}, wait_cnt
//    matches bench count; stat_clear_i pulse -> all 0 next cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one single-beat memory port.
// Define MEM_ARB_STATS_EN to add per-requester grant/wait counters.
module mem_bus_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int ADDR_WIDTH      = 16,
    parameter int BUS_WIDTH_BYTES = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ-1:0]                   we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        addr_i,
    input  logic [NUM_REQ*8*BUS_WIDTH_BYTES-1:0] wdata_i,
    output logic [NUM_REQ-1:0]                   ack_o,
    output logic [8*BUS_WIDTH_BYTES-1:0]         rdata_o,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [8*BUS_WIDTH_BYTES-1:0]         mem_wdata_o,
`ifdef MEM_ARB_STATS_EN
    input  logic                                 stat_clear_i,
    output logic [NUM_REQ*32-1:0]                grant_cnt_o,
    output logic [NUM_REQ*32-1:0]                wait_cnt_o,
`endif
    input  logic                                 mem_ack_i,
    input  logic [8*BUS_WIDTH_BYTES-1:0]         mem_rdata_i
);

    localparam int DW = 8 * BUS_WIDTH_BYTES;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] rr;
    logic [IW-1:0] grant;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    int            c;

    // First requester at or after the rr pointer, wrapping past NUM_REQ-1.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        c     = 0;
        cand  = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            c = int'(rr) + o;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            cand = IW'(c);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   if (mem_ack_i) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr          <= '0;
            grant       <= '0;
            ack_o       <= '0;
            rdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            ack_o <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant       <= pick;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= we_i[pick];
                        mem_addr_o  <= addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata_o <= wdata_i[pick*DW +: DW];
                    end
                end
                ISSUE: begin
                    if (mem_ack_i) begin
                        mem_req_o    <= 1'b0;
                        ack_o[grant] <= 1'b1;
                        // Write acks leave the last read value in place.
                        if (!mem_we_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                    end
                end
                RESP: begin
                    if (grant == IW'(NUM_REQ - 1)) begin
                        rr <= '0;
                    end else begin
                        rr <= grant + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];
    logic [31:0] wait_cnt  [NUM_REQ];

    // Saturating counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
                wait_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stat_clear_i) begin
                    grant_cnt[i] <= '0;
                    wait_cnt[i]  <= '0;
                end else begin
                    if (ack_o[i] && (grant_cnt[i] != '1)) begin
                        grant_cnt[i] <= grant_cnt[i] + 32'd1;
                    end
                    if (req_i[i] && !ack_o[i] && (wait_cnt[i] != '1)) begin
                        wait_cnt[i] <= wait_cnt[i] + 32'd1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign grant_cnt_o[g*32 +: 32] = grant_cnt[g];
        assign wait_cnt_o[g*32 +: 32]  = wait_cnt[g];
    end
`else
    // Statistics disabled: no counters, arbitration unchanged.
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of reset, reads, writes,
// round-robin contention and back-to-back fairness.
module tb_mem_bus_arbiter;

    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 256;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_i;
    logic [NR-1:0]     we_i;
    logic [NR*AW-1:0]  addr_i;
    logic [NR*DW-1:0]  wdata_i;
    logic [NR-1:0]     ack_o;
    logic [DW-1:0]     rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              mem_ack_i;
    logic [DW-1:0]     mem_rdata_i;
`ifdef MEM_ARB_STATS_EN
    logic              stat_clear_i;
    logic [NR*32-1:0]  grant_cnt_o;
    logic [NR*32-1:0]  wait_cnt_o;
`endif

    int checks = 0;
    int fails  = 0;

    localparam logic [DW-1:0] RD_A5 = {32{8'hA5}};
    localparam logic [DW-1:0] RD_3C = {32{8'h3C}};
    localparam logic [DW-1:0] RD_EE = {32{8'hEE}};

    mem_bus_arbiter #(
        .NUM_REQ(NR),
        .ADDR_WIDTH(AW),
        .BUS_WIDTH_BYTES(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_i(req_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .ack_o(ack_o),
        .rdata_o(rdata_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
`ifdef MEM_ARB_STATS_EN
        .stat_clear_i(stat_clear_i),
        .grant_cnt_o(grant_cnt_o),
        .wait_cnt_o(wait_cnt_o),
`endif
        .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n   = 1'b0;
        req_i     = '0;
        we_i      = '0;
        mem_ack_i = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        addr_i      = '0;
        wdata_i     = '0;
        mem_rdata_i = '0;
`ifdef MEM_ARB_STATS_EN
        stat_clear_i = 1'b0;
`endif
        do_reset();
        checks++;
        if (mem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mem_req: got %b want 0", mem_req_o);
        end
        checks++;
        if (ack_o !== 3'b000) begin
            fails++;
            $display("FAIL rst_ack: got %b want 000", ack_o);
        end
        checks++;
        if (rdata_o !== '0 || mem_addr_o !== '0 || mem_we_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_regs: rdata %h addr %h we %b want 0",
                     rdata_o, mem_addr_o, mem_we_o);
        end
        addr_i[0*AW +: AW] = 16'h00AA;
        req_i = 3'b001;
        tick();
        checks++;
        if (mem_req_o !== 1'b1) begin
            fails++;
            $display("FAIL pre_rst_issue: got %b want 1", mem_req_o);
        end
        req_i   = '0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || ack_o !== 3'b000) begin
            fails++;
            $display("FAIL mid_rst: mem_req %b ack %b want 0 000",
                     mem_req_o, ack_o);
        end
        tick();
        reset_n = 1'b1;
        addr_i[1*AW +: AW] = 16'h0B00;
        req_i = 3'b010;
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0B00) begin
            fails++;
            $display("FAIL post_rst_grant: mem_req %b addr %h want 1 0b00",
                     mem_req_o, mem_addr_o);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++;
        if (ack_o !== 3'b010) begin
            fails++;
            $display("FAIL post_rst_ack: got %b want 010", ack_o);
        end
        req_i = '0;
        tick();
    endtask

    // rr is 2 here; a lone A request still wins after the wrap.
    task automatic test_single_read;
        addr_i[0*AW +: AW] = 16'h0040;
        mem_rdata_i = RD_A5;
        req_i = 3'b001;
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0040 || mem_we_o !== 1'b0) begin
            fails++;
            $display("FAIL rd_issue: req %b addr %h we %b want 1 0040 0",
                     mem_req_o, mem_addr_o, mem_we_o);
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || ack_o !== 3'b000) begin
            fails++;
            $display("FAIL rd_wait: req %b ack %b want 1 000", mem_req_o, ack_o);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++;
        if (ack_o !== 3'b001) begin
            fails++;
            $display("FAIL rd_ack: got %b want 001", ack_o);
        end
        checks++;
        if (rdata_o !== RD_A5) begin
            fails++;
            $display("FAIL rd_data: got %h want %h", rdata_o, RD_A5);
        end
        checks++;
        if (mem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL rd_req_drop: got %b want 0", mem_req_o);
        end
        req_i = '0;
        tick();
        checks++;
        if (ack_o !== 3'b000) begin
            fails++;
            $display("FAIL rd_ack_pulse: got %b want 000", ack_o);
        end
    endtask

    task automatic test_contention;
        logic [NR-1:0] exp_ack [4];
        logic [AW-1:0] exp_adr [4];
        int n;
        int cyc;
        int last;
        exp_ack[0] = 3'b001; exp_adr[0] = 16'h0100;
        exp_ack[1] = 3'b010; exp_adr[1] = 16'h0200;
        exp_ack[2] = 3'b100; exp_adr[2] = 16'h0300;
        exp_ack[3] = 3'b001; exp_adr[3] = 16'h0100;
        do_reset();
        addr_i[0*AW +: AW] = 16'h0100;
        addr_i[1*AW +: AW] = 16'h0200;
        addr_i[2*AW +: AW] = 16'h0300;
        mem_rdata_i = RD_3C;
        req_i     = 3'b111;
        mem_ack_i = 1'b1;
        n = 0;
        cyc = 0;
        last = 0;
        while (n < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (ack_o !== 3'b000) begin
                checks++;
                if (ack_o !== exp_ack[n] || mem_addr_o !== exp_adr[n]) begin
                    fails++;
                    $display("FAIL rr_grant%0d: ack %b addr %h want %b %h",
                             n, ack_o, mem_addr_o, exp_ack[n], exp_adr[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        fails++;
                        $display("FAIL rr_spacing%0d: got %0d want 3", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            fails++;
            $display("FAIL rr_timeout: got %0d acks want 4", n);
        end
        checks++;
        if (rdata_o !== RD_3C) begin
            fails++;
            $display("FAIL rr_rdata: got %h want %h", rdata_o, RD_3C);
        end
        req_i     = '0;
        mem_ack_i = 1'b0;
        tick();
    endtask

    // rr is 1 here; C alone is granted.
    task automatic test_write;
        mem_rdata_i = RD_EE;
        addr_i[2*AW +: AW]  = 16'h1000;
        wdata_i[2*DW +: DW] = 256'h1234;
        we_i  = 3'b100;
        req_i = 3'b100;
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 16'h1000) begin
            fails++;
            $display("FAIL wr_issue: req %b we %b addr %h want 1 1 1000",
                     mem_req_o, mem_we_o, mem_addr_o);
        end
        checks++;
        if (mem_wdata_o !== 256'h1234) begin
            fails++;
            $display("FAIL wr_data: got %h want 1234", mem_wdata_o);
        end
        addr_i[2*AW +: AW]  = 16'h2222;
        wdata_i[2*DW +: DW] = 256'hFFFF;
        tick();
        checks++;
        if (mem_addr_o !== 16'h1000 || mem_wdata_o !== 256'h1234) begin
            fails++;
            $display("FAIL wr_latched: addr %h data %h want 1000 1234",
                     mem_addr_o, mem_wdata_o);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++;
        if (ack_o !== 3'b100) begin
            fails++;
            $display("FAIL wr_ack: got %b want 100", ack_o);
        end
        checks++;
        if (rdata_o !== RD_3C) begin
            fails++;
            $display("FAIL wr_rdata_hold: got %h want %h", rdata_o, RD_3C);
        end
        req_i = '0;
        we_i  = '0;
        tick();
    endtask

    // rr is 0; A re-requests after its ack but B must go first.
    task automatic test_back_to_back;
        logic [NR-1:0] exp_ack [3];
        int n;
        int cyc;
        exp_ack[0] = 3'b001;
        exp_ack[1] = 3'b010;
        exp_ack[2] = 3'b001;
        req_i     = 3'b011;
        mem_ack_i = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 30) begin
            tick();
            cyc++;
            if (ack_o !== 3'b000) begin
                checks++;
                if (ack_o !== exp_ack[n]) begin
                    fails++;
                    $display("FAIL b2b_order%0d: got %b want %b", n, ack_o, exp_ack[n]);
                end
                if (ack_o[1]) begin
                    req_i[1] = 1'b0;
                end
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            fails++;
            $display("FAIL b2b_timeout: got %0d acks want 3", n);
        end
        req_i     = '0;
        mem_ack_i = 1'b0;
        tick();
        checks++;
        if (ack_o !== 3'b000 || mem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: ack %b req %b want 000 0", ack_o, mem_req_o);
        end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats;
        int mg [NR];
        int mw [NR];
        int n;
        int cyc;
        for (int i = 0; i < NR; i++) begin
            mg[i] = 0;
            mw[i] = 0;
        end
        do_reset();
        req_i     = 3'b111;
        mem_ack_i = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 60) begin
            for (int i = 0; i < NR; i++) begin
                if (ack_o[i]) mg[i]++;
                if (req_i[i] && !ack_o[i]) mw[i]++;
            end
            tick();
            cyc++;
            if (ack_o !== 3'b000) n++;
        end
        req_i     = '0;
        mem_ack_i = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (ack_o[i]) mg[i]++;
        end
        tick();
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (grant_cnt_o[i*32 +: 32] !== 32'd2 || mg[i] != 2) begin
                fails++;
                $display("FAIL st_grant%0d: got %0d want 2", i, grant_cnt_o[i*32 +: 32]);
            end
            checks++;
            if (wait_cnt_o[i*32 +: 32] !== 32'(mw[i])) begin
                fails++;
                $display("FAIL st_wait%0d: got %0d want %0d", i,
                         wait_cnt_o[i*32 +: 32], mw[i]);
            end
        end
        stat_clear_i = 1'b1;
        tick();
        stat_clear_i = 1'b0;
        checks++;
        if (grant_cnt_o !== '0 || wait_cnt_o !== '0) begin
            fails++;
            $display("FAIL st_clear: grant %h wait %h want 0", grant_cnt_o, wait_cnt_o);
        end
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        req_i     = '0;
        we_i      = '0;
        mem_ack_i = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_back_to_back();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
